// File: rtl/irq_controller.sv
// Interrupt controller with per-source enable and edge/level mode, driving active-low IRQB.
// Define IRQ_CTRL_VECTOR_EN to build the ACTIVE priority encoder at 0xC; otherwise 0xC reads 0x00.
module irq_controller #(
  parameter int                     NUM_SOURCES  = 8,
  parameter logic [NUM_SOURCES-1:0] ENABLE_RESET = '1,
  parameter logic [NUM_SOURCES-1:0] EDGE_RESET   = '1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cs,
  input  logic                   rw,
  input  logic [3:0]             addr,
  input  logic [7:0]             data_in,
  output logic [7:0]             data_out,
  input  logic [NUM_SOURCES-1:0] src,
  output logic                   irq_n
);

  localparam int N = NUM_SOURCES;

  logic [N-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [N-1:0] pending_q, pending_d, enable_q, enable_d, edge_q, edge_d;
  logic         gen_q, gen_d, irq_n_q, irq_n_d;

  logic         wr;
  logic [31:0]  lane_data, lane_mask;
  logic [N-1:0] wdata, wmask, rise, w1c;
  logic [31:0]  pend_w, enable_w, edge_w;
  logic [7:0]   active;
  logic         unused_lane_bits;

  // Place the written byte into its lane across the full 32-bit source space.
  always_comb begin
    wr        = cs && !rw;
    lane_data = {24'd0, data_in} << {addr[1:0], 3'b000};
    lane_mask = 32'h0000_00FF << {addr[1:0], 3'b000};
    wdata     = lane_data[N-1:0];
    wmask     = lane_mask[N-1:0];
  end

  assign unused_lane_bits = ^{lane_data, lane_mask};

  always_comb begin
    s1_d     = src;
    s2_d     = s1_q;
    s3_d     = s2_q;
    rise     = s2_q & ~s3_q;
    w1c      = (wr && addr[3:2] == 2'b00) ? wdata : '0;
    enable_d = enable_q;
    edge_d   = edge_q;
    gen_d    = gen_q;
    // A rise outranks a simultaneous clear; level-mode bits just track the synchroniser.
    pending_d = (edge_q & ((pending_q & ~w1c) | rise)) | (~edge_q & s2_q);
    if (wr && addr[3:2] == 2'b01) enable_d = (enable_q & ~wmask) | wdata;
    if (wr && addr[3:2] == 2'b10) edge_d = (edge_q & ~wmask) | wdata;
    if (wr && addr == 4'hD) gen_d = data_in[0];
    irq_n_d = ~(gen_q & |(pending_q & enable_q));
  end

`ifdef IRQ_CTRL_VECTOR_EN
  logic [N-1:0] hit;

  // Scanning from the top leaves the lowest enabled pending index in place.
  always_comb begin
    hit    = pending_q & enable_q;
    active = 8'h00;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit[i]) active = {1'b1, 2'b00, 5'(i)};
    end
  end
`else
  assign active = 8'h00;
`endif

  always_comb begin
    pend_w           = '0;
    enable_w         = '0;
    edge_w           = '0;
    pend_w[N-1:0]    = pending_q;
    enable_w[N-1:0]  = enable_q;
    edge_w[N-1:0]    = edge_q;
    data_out         = 8'h00;
    case (addr[3:2])
      2'b00:   data_out = pend_w[{addr[1:0], 3'b000} +: 8];
      2'b01:   data_out = enable_w[{addr[1:0], 3'b000} +: 8];
      2'b10:   data_out = edge_w[{addr[1:0], 3'b000} +: 8];
      default: begin
        if (addr[1:0] == 2'b00) data_out = active;
        else if (addr[1:0] == 2'b01) data_out = {7'd0, gen_q};
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      pending_q <= '0;
      enable_q  <= ENABLE_RESET;
      edge_q    <= EDGE_RESET;
      gen_q     <= 1'b1;
      irq_n_q   <= 1'b1;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      edge_q    <= edge_d;
      gen_q     <= gen_d;
      irq_n_q   <= irq_n_d;
    end
  end

  assign irq_n = irq_n_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus randomized bus/source
// traffic on an 8-source instance against a behavioural model, and lane checks on a 12-source instance.
module tb_irq_controller;

`ifdef IRQ_CTRL_VECTOR_EN
  localparam logic VEC = 1'b1;
`else
  localparam logic VEC = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        cs, rw;
  logic [3:0]  addr;
  logic [7:0]  data_in, data_out;
  logic [7:0]  src;
  logic        irq_n;

  logic        cs12, rw12;
  logic [3:0]  addr12;
  logic [7:0]  din12, dout12;
  logic [11:0] src12;
  logic        irq_n12;

  int n_checks = 0;
  int n_fail   = 0;

  irq_controller dut (
    .clk(clk), .rst(rst), .cs(cs), .rw(rw), .addr(addr),
    .data_in(data_in), .data_out(data_out), .src(src), .irq_n(irq_n)
  );

  irq_controller #(.NUM_SOURCES(12)) dut12 (
    .clk(clk), .rst(rst), .cs(cs12), .rw(rw12), .addr(addr12),
    .data_in(din12), .data_out(dout12), .src(src12), .irq_n(irq_n12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the 8-source instance: register contents plus a record of
  // what src looked like at the last three clock edges.
  logic [7:0] m_pend, m_en, m_edge;
  logic       m_gen, m_irqn;
  logic [7:0] src_ago1, src_ago2, src_ago3;

  function automatic logic [7:0] next_pending();
    logic [7:0] p;
    p = m_pend;
    for (int i = 0; i < 8; i++) begin
      if (!m_edge[i]) p[i] = src_ago2[i];
      else if (src_ago2[i] && !src_ago3[i]) p[i] = 1'b1;
      else if (cs && !rw && addr == 4'h0 && data_in[i]) p[i] = 1'b0;
      else p[i] = m_pend[i];
    end
    return p;
  endfunction

  function automatic logic [7:0] model_read(input logic [3:0] a);
    logic [7:0] r;
    logic [7:0] hit;
    logic       found;
    r     = 8'h00;
    hit   = m_pend & m_en;
    found = 1'b0;
    case (a)
      4'h0: r = m_pend;
      4'h4: r = m_en;
      4'h8: r = m_edge;
      4'hD: r = {7'd0, m_gen};
      4'hC: begin
        if (VEC) begin
          for (int i = 0; i < 8; i++) begin
            if (hit[i] && !found) begin
              found = 1'b1;
              r = 8'h80 | 8'(i);
            end
          end
        end
      end
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend   <= 8'h00;
      m_en     <= 8'hFF;
      m_edge   <= 8'hFF;
      m_gen    <= 1'b1;
      m_irqn   <= 1'b1;
      src_ago1 <= 8'h00;
      src_ago2 <= 8'h00;
      src_ago3 <= 8'h00;
    end else begin
      m_irqn <= ~(m_gen & (|(m_pend & m_en)));
      m_pend <= next_pending();
      if (cs && !rw) begin
        case (addr)
          4'h4:    m_en   <= data_in;
          4'h8:    m_edge <= data_in;
          4'hD:    m_gen  <= data_in[0];
          default: ;
        endcase
      end
      src_ago1 <= src;
      src_ago2 <= src_ago1;
      src_ago3 <= src_ago2;
    end
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %02h expected %02h", tag, observed, expected);
    end
  endtask

  // Continuous comparison of the 8-source instance against the model every cycle.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      checkOutput("model_irq_n", {7'd0, irq_n}, {7'd0, m_irqn});
      if (cs && rw) checkOutput("model_read", data_out, model_read(addr));
    end
  end

  task automatic applyStimulus(input logic c, input logic r, input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    cs      = c;
    rw      = r;
    addr    = a;
    data_in = d;
  endtask

  task automatic readCheck(input logic [3:0] a, input logic [7:0] exp, input string tag);
    applyStimulus(1'b1, 1'b1, a, 8'h00);
    #2;
    checkOutput(tag, data_out, exp);
  endtask

  task automatic idleIrqCheck(input logic exp, input string tag);
    applyStimulus(1'b0, 1'b1, 4'h0, 8'h00);
    #2;
    checkOutput(tag, {7'd0, irq_n}, {7'd0, exp});
  endtask

  task automatic readCheck12(input logic [3:0] a, input logic [7:0] exp, input string tag);
    @(negedge clk);
    cs12   = 1'b1;
    rw12   = 1'b1;
    addr12 = a;
    #2;
    checkOutput(tag, dout12, exp);
  endtask

  task automatic write12(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    cs12   = 1'b1;
    rw12   = 1'b0;
    addr12 = a;
    din12  = d;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cs = 1'b0; rw = 1'b1; addr = 4'h0; data_in = 8'h00; src = 8'h00;
    cs12 = 1'b0; rw12 = 1'b1; addr12 = 4'h0; din12 = 8'h00; src12 = 12'h000;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    checkOutput("rst_irq_n", {7'd0, irq_n}, 8'h01);
    readCheck(4'h0, 8'h00, "rst_pending");
    readCheck(4'h4, 8'hFF, "rst_enable");
    readCheck(4'h8, 8'hFF, "rst_edge");
    readCheck(4'hD, 8'h01, "rst_ctrl");
    readCheck(4'hE, 8'h00, "reserved_e");

    // Two-cycle pulse on src[1]: irq_n low three edges after first sample
    applyStimulus(1'b0, 1'b1, 4'h0, 8'h00); src = 8'h02;
    applyStimulus(1'b0, 1'b1, 4'h0, 8'h00);
    applyStimulus(1'b0, 1'b1, 4'h0, 8'h00); src = 8'h00;
    idleIrqCheck(1'b1, "pulse_irq_k2");
    idleIrqCheck(1'b0, "pulse_irq_k3");
    readCheck(4'h0, 8'h02, "pulse_pending");
    readCheck(4'hC, VEC ? 8'h81 : 8'h00, "pulse_active");
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h02);
    cs = 1'b1;
    readCheck(4'h0, 8'h00, "w1c_pending");
    idleIrqCheck(1'b1, "w1c_irq_n");

    // Level mode on bit 0: W1C has no effect, bit follows the source
    applyStimulus(1'b1, 1'b0, 4'h8, 8'hFE); src = 8'h01;
    repeat (4) applyStimulus(1'b0, 1'b1, 4'h0, 8'h00);
    applyStimulus(1'b1, 1'b0, 4'h0, 8'h01);
    applyStimulus(1'b1, 1'b0, 4'h0, 8'h01);
    readCheck(4'h0, 8'h01, "level_w1c_ignored");
    applyStimulus(1'b0, 1'b1, 4'h0, 8'h00); src = 8'h00;
    repeat (3) applyStimulus(1'b0, 1'b1, 4'h0, 8'h00);
    readCheck(4'h0, 8'h00, "level_drop");
    idleIrqCheck(1'b1, "level_irq_n");
    applyStimulus(1'b1, 1'b0, 4'h8, 8'hFF);

    // Bits 3 and 5 pending, bit 3 masked
    applyStimulus(1'b0, 1'b1, 4'h0, 8'h00); src = 8'h28;
    applyStimulus(1'b0, 1'b1, 4'h0, 8'h00);
    applyStimulus(1'b0, 1'b1, 4'h0, 8'h00); src = 8'h00;
    repeat (2) applyStimulus(1'b0, 1'b1, 4'h0, 8'h00);
    applyStimulus(1'b1, 1'b0, 4'h4, 8'hF7);
    readCheck(4'hC, VEC ? 8'h85 : 8'h00, "active_masked");
    applyStimulus(1'b1, 1'b0, 4'h4, 8'h00);
    applyStimulus(1'b0, 1'b1, 4'h0, 8'h00);
    idleIrqCheck(1'b1, "mask_irq_n");
    readCheck(4'h0, 8'h28, "mask_pending_kept");
    applyStimulus(1'b1, 1'b0, 4'h0, 8'h28);
    applyStimulus(1'b1, 1'b0, 4'h4, 8'hFF);

    // W1C of bit 2 on the same edge as a fresh rise on bit 2
    applyStimulus(1'b0, 1'b1, 4'h0, 8'h00); src = 8'h04;
    applyStimulus(1'b0, 1'b1, 4'h0, 8'h00);
    applyStimulus(1'b0, 1'b1, 4'h0, 8'h00); src = 8'h00;
    repeat (3) applyStimulus(1'b0, 1'b1, 4'h0, 8'h00);
    applyStimulus(1'b0, 1'b1, 4'h0, 8'h00); src = 8'h04;
    applyStimulus(1'b0, 1'b1, 4'h0, 8'h00);
    applyStimulus(1'b1, 1'b0, 4'h0, 8'h04);
    readCheck(4'h0, 8'h04, "set_beats_clear");
    src = 8'h00;
    repeat (4) applyStimulus(1'b1, 1'b0, 4'h0, 8'h04);
    readCheck(4'h0, 8'h00, "repeat_w1c");
    repeat (4) applyStimulus(1'b1, 1'b0, 4'h4, 8'h5A);
    readCheck(4'h4, 8'h5A, "repeat_enable");
    applyStimulus(1'b1, 1'b0, 4'h4, 8'hFF);

    // Randomized traffic checked by the model
    for (int c = 0; c < 1500; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), 8'($urandom));
      if ($urandom_range(0, 3) == 0) src = src ^ 8'($urandom);
    end
    applyStimulus(1'b0, 1'b1, 4'h0, 8'h00);
    src = 8'h00;

    // 12-source instance: partial and empty lanes
    readCheck12(4'h4, 8'hFF, "n12_enable_lane0");
    readCheck12(4'h5, 8'h0F, "n12_enable_lane1");
    readCheck12(4'h6, 8'h00, "n12_enable_lane2");
    readCheck12(4'h7, 8'h00, "n12_enable_lane3");
    readCheck12(4'h9, 8'h0F, "n12_edge_lane1");
    write12(4'h5, 8'hF0);
    readCheck12(4'h5, 8'h00, "n12_upper_write_ignored");
    write12(4'h5, 8'hFF);
    readCheck12(4'h5, 8'h0F, "n12_enable_restored");
    @(negedge clk); src12 = 12'h200;
    repeat (4) @(negedge clk);
    readCheck12(4'h1, 8'h02, "n12_pending_lane1");
    readCheck12(4'h2, 8'h00, "n12_pending_lane2");
    readCheck12(4'h0, 8'h00, "n12_pending_lane0");
    checkOutput("n12_irq_low", {7'd0, irq_n12}, 8'h00);

    // Reset mid-pulse clears state without waiting for a clock edge
    readCheck12(4'h1, 8'h02, "n12_pre_reset");
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("midrst_irq_n12", {7'd0, irq_n12}, 8'h01);
    checkOutput("midrst_pending12", dout12, 8'h00);
    checkOutput("midrst_irq_n", {7'd0, irq_n}, 8'h01);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    checkOutput("n12_rise_after_reset", dout12, 8'h02);
    cs12 = 1'b0;

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
